reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   General-purpose register file with 2 combinational read ports and 1 synchronous write port.
//   Four registers of 32 bits each.
//   Sits between decode and execute in the datapath.
//   Supplies two source operands per cycle and accepts one write-back per clock.
// PARAMETERS
//   DATA_WIDTH  32  width of each register and of the data ports
//   ADDR_WIDTH  2   register-select width; register count = 2**ADDR_WIDTH (4)
// PORTS
//   clk          in   1           clock; all state updates on the rising edge
//   reset        in   1           asynchronous, active-high; clears every register
//   readreg1     in   ADDR_WIDTH  read port 1 register select
//   readreg2     in   ADDR_WIDTH  read port 2 register select
//   writeReg     in   ADDR_WIDTH  write port register select
//   writeData    in   DATA_WIDTH  data to write
//   writeEnable  in   1           write strobe, sampled at posedge clk
//   readData1    out  DATA_WIDTH  contents of register readreg1
//   readData2    out  DATA_WIDTH  contents of register readreg2
// BEHAVIOUR
//   - Ports are connected positionally, in exactly the order listed above.
//   - Reset:
//     - reset=1 clears all registers to 0 immediately, without waiting for a clock edge.
//     - While reset stays high, the registers hold 0 and writes are ignored.
//     - Both read outputs therefore read 0 during and after reset until a write occurs.
//     - Reset asserted mid-write takes priority, so the register stays 0.
//   - Write:
//     - On posedge clk with reset=0 and writeEnable=1: reg[writeReg] <= writeData.
//     - With writeEnable=0 the contents are unchanged.
//     - writeData and writeReg are don't-care when writeEnable=0.
//   - Read:
//     - Purely combinational with zero latency: readDataN = reg[readregN].
//     - readDataN changes in the same timestep as readregN changes.
//   - Read-during-write to the same register:
//     - Before the edge, the read port returns the OLD value; there is no bypass.
//     - The new value appears right after the rising edge that performs the write.
//   - Both read ports may select the same register, or the register being written, at the same time.
//   - All registers, including reg 0, are ordinary writable registers. Reg 0 is not hardwired to zero.
//   - X or Z on a read select drives X on that read output only. It must not corrupt stored state.
//   - No other state exists: no pipeline or handshake.
// TESTING
//   - Reset:
//     - Assert reset=1 for 2 time units, then release.
//     - Required: readData1=readData2=32'h0 for every readreg value.
//   - Basic write/read:
//     - writeEnable=1, writeReg=2'b01, writeData=32'h000000a1, one posedge.
//     - Then writeEnable=0, readreg1=01, readreg2=00.
//     - Required: readData1=32'h000000a1, readData2=32'h0.
//   - Write disabled:
//     - writeEnable=0, writeReg=2'b10, writeData=32'hDEADBEEF, several edges.
//     - Required: reading reg 2 gives 32'h0.
//   - All registers:
//     - Write 32'h11111111, 32'h22222222, 32'h33333333 and 32'h44444444 to regs 0..3.
//     - Read every pair on both ports.
//     - Required: each port returns the matching value. Reg 0 returns 32'h11111111.
//   - Read-during-write:
//     - Reg 1 holds 32'hA1. Write 32'h55 to reg 1 with readreg1=01.
//     - Required: readData1=32'hA1 before the edge and 32'h55 after it.
//   - Async reset mid-operation:
//     - Registers are loaded. Assert reset between clock edges.
//     - Required: all outputs go to 0 before the next posedge.
//     - A write attempted while reset=1 is ignored.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: small general-purpose register file between decode and execute.
// Two zero-latency combinational read ports and one write port that updates on the
// rising clock edge. Reads never bypass a same-cycle write: the old value is visible
// until the edge that performs the write. Every register, including reg 0, is writable.
module reg_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] readreg1,
    input  logic [ADDR_WIDTH-1:0] readreg2,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  writeEnable,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];
    logic [DATA_WIDTH-1:0] regs_d [NumRegs];

    // Next-state: hold every register, load the addressed one when writing.
    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            regs_d[i] = regs_q[i];
            if (writeEnable && (writeReg == ADDR_WIDTH'(i))) begin
                regs_d[i] = writeData;
            end
        end
    end

    // State: async reset clears everything and blocks writes while it is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports: straight mux off the stored state, no write bypass.
    always_comb begin
        readData1 = regs_q[readreg1];
        readData2 = regs_q[readreg2];
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven bench for reg_file plus hand sequences for reset,
// read-during-write and asynchronous reset between clock edges.
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic [1:0]  readreg1;
    logic [1:0]  readreg2;
    logic [1:0]  writeReg;
    logic [31:0] writeData;
    logic        writeEnable;
    logic [31:0] readData1;
    logic [31:0] readData2;

    int checks;
    int errors;

    typedef struct packed {
        logic        we;
        logic [1:0]  wreg;
        logic [31:0] wdata;
        logic [1:0]  r1;
        logic [1:0]  r2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] model [4];

    reg_file dut (
        .clk         (clk),
        .reset       (reset),
        .readreg1    (readreg1),
        .readreg2    (readreg2),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .readData1   (readData1),
        .readData2   (readData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        readreg1    = 2'd0;
        readreg2    = 2'd0;
        writeReg    = 2'd0;
        writeData   = 32'h0;
        writeEnable = 1'b0;

        // Post-edge expectations, hand-computed.
        vecs[0] = '{1'b1, 2'd1, 32'h000000a1, 2'd1, 2'd0, 32'h000000a1, 32'h00000000};
        vecs[1] = '{1'b0, 2'd2, 32'hdeadbeef, 2'd2, 2'd1, 32'h00000000, 32'h000000a1};
        vecs[2] = '{1'b0, 2'd2, 32'hdeadbeef, 2'd2, 2'd2, 32'h00000000, 32'h00000000};
        vecs[3] = '{1'b1, 2'd0, 32'h11111111, 2'd0, 2'd1, 32'h11111111, 32'h000000a1};
        vecs[4] = '{1'b1, 2'd1, 32'h22222222, 2'd1, 2'd1, 32'h22222222, 32'h22222222};
        vecs[5] = '{1'b1, 2'd2, 32'h33333333, 2'd2, 2'd1, 32'h33333333, 32'h22222222};
        vecs[6] = '{1'b1, 2'd3, 32'h44444444, 2'd3, 2'd0, 32'h44444444, 32'h11111111};
        model[0] = 32'h11111111;
        model[1] = 32'h22222222;
        model[2] = 32'h33333333;
        model[3] = 32'h44444444;

        // Reset for 2 time units, reads are zero during and after it.
        reset = 1'b1;
        #1;
        check("reset_during_rd1", readData1, 32'h0);
        check("reset_during_rd2", readData2, 32'h0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            readreg1 = 2'(i);
            readreg2 = 2'(3 - i);
            #1;
            check("reset_rd1", readData1, 32'h0);
            check("reset_rd2", readData2, 32'h0);
        end

        // Table-driven write/read vectors.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            writeEnable = vecs[v].we;
            writeReg    = vecs[v].wreg;
            writeData   = vecs[v].wdata;
            readreg1    = vecs[v].r1;
            readreg2    = vecs[v].r2;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rd1", v), readData1, vecs[v].exp1);
            check($sformatf("vec%0d_rd2", v), readData2, vecs[v].exp2);
        end

        // Every read-select pair on both ports, combinational.
        @(negedge clk);
        writeEnable = 1'b0;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                readreg1 = 2'(a);
                readreg2 = 2'(b);
                #1;
                check($sformatf("pair%0d%0d_rd1", a, b), readData1, model[a]);
                check($sformatf("pair%0d%0d_rd2", a, b), readData2, model[b]);
            end
        end

        // Read-during-write: reg 1 holds A1, write 55, old value until the edge.
        @(negedge clk);
        writeEnable = 1'b1;
        writeReg    = 2'd1;
        writeData   = 32'h000000a1;
        @(negedge clk);
        writeData   = 32'h00000055;
        readreg1    = 2'd1;
        readreg2    = 2'd1;
        #1;
        check("rdw_before_rd1", readData1, 32'h000000a1);
        check("rdw_before_rd2", readData2, 32'h000000a1);
        @(posedge clk);
        #1;
        check("rdw_after_rd1", readData1, 32'h00000055);
        check("rdw_after_rd2", readData2, 32'h00000055);
        writeEnable = 1'b0;

        // Async reset between edges, with a write pending, clears at once.
        @(negedge clk);
        readreg1    = 2'd3;
        readreg2    = 2'd0;
        #1;
        check("preload_rd1", readData1, 32'h44444444);
        writeEnable = 1'b1;
        writeReg    = 2'd2;
        writeData   = 32'h00000077;
        #1;
        reset = 1'b1;
        #1;
        check("async_rd1", readData1, 32'h0);
        check("async_rd2", readData2, 32'h0);
        readreg1 = 2'd2;
        readreg2 = 2'd1;
        @(posedge clk);
        #1;
        check("reset_wr_ignored_rd1", readData1, 32'h0);
        check("reset_wr_ignored_rd2", readData2, 32'h0);
        @(negedge clk);
        reset       = 1'b0;
        writeEnable = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_hold", readData1, 32'h0);

        // Writes work again after reset, including reg 0.
        @(negedge clk);
        writeEnable = 1'b1;
        writeReg    = 2'd0;
        writeData   = 32'hcafef00d;
        readreg1    = 2'd0;
        readreg2    = 2'd2;
        @(posedge clk);
        #1;
        check("reg0_write_rd1", readData1, 32'hcafef00d);
        check("reg0_write_rd2", readData2, 32'h0);
        writeEnable = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
